// File: rtl/serial_cmd_ctrl.sv
// Byte-serial command controller: assembles 5-byte frames from the UART receiver,
// drives RAM requests and streams a 4-byte reply. Optional partial-frame timeout: CMD_TIMEOUT_EN.
module serial_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] COUNT_INIT     = 32'd260,
  parameter logic [31:0] CONST_WORD     = 32'h01010101
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_strb,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wr_req,
  output logic        ram_rd_req,
  input  logic        ram_busy,
  input  logic        ram_rd_valid,
  input  logic [31:0] ram_rdata,
  output logic        rx_overrun
);

  localparam int unsigned FRAME_W    = 40;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned FRAME_LAST = 4;
  localparam int unsigned REPLY_LEN  = 4;

  localparam logic [BYTE_W-1:0] CMD_ADDR     = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_LOAD     = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_WRITE    = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_READ     = 8'h04;
  localparam logic [BYTE_W-1:0] CMD_READ_REQ = 8'h05;
  localparam logic [BYTE_W-1:0] CMD_COUNT    = 8'h06;
  localparam logic [BYTE_W-1:0] CMD_CONST    = 8'h07;

  localparam logic [WORD_W-1:0] REPLY_WRITE    = 32'h0000_0003;
  localparam logic [WORD_W-1:0] REPLY_READ_REQ = 32'h0000_0005;
  localparam logic [WORD_W-1:0] REPLY_BAD      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_RX,
    S_EXEC,
    S_TX_LOAD,
    S_TX_WAIT
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  frame;
  logic [CNT_W-1:0]    byte_cnt;
  logic [CNT_W-1:0]    tx_cnt;
  logic [WORD_W-1:0]   reply;
  logic [WORD_W-1:0]   rd_buf;
  logic [WORD_W-1:0]   count;

  logic [BYTE_W-1:0]   cmd_c;
  logic [WORD_W-1:0]   payload_c;
  logic                exec_stall_c;

  assign cmd_c     = frame[FRAME_W-1 -: BYTE_W];
  assign payload_c = frame[WORD_W-1:0];

  // RAM-request commands hold EXEC until the controller can accept them
  assign exec_stall_c = ((cmd_c == CMD_WRITE) || (cmd_c == CMD_READ_REQ)) && ram_busy;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit_c;

  assign to_hit_c = (state == S_RX) && (byte_cnt != '0) && !rx_strb &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter for an open partial frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if ((state != S_RX) || (byte_cnt == '0) || rx_strb || to_hit_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Last read data returned by the RAM controller, captured in any state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_buf <= '0;
    end else if (ram_rd_valid) begin
      rd_buf <= ram_rdata;
    end
  end

  // Frame assembly, command execution and reply streaming
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RX;
      frame      <= '0;
      byte_cnt   <= '0;
      tx_cnt     <= '0;
      reply      <= '0;
      count      <= COUNT_INIT;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wr_req <= 1'b0;
      ram_rd_req <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      ram_wr_req <= 1'b0;
      ram_rd_req <= 1'b0;

      if (rx_strb && (state != S_RX)) begin
        rx_overrun <= 1'b1;
      end

      case (state)
        S_RX: begin
          if (rx_strb) begin
            frame <= {frame[FRAME_W-BYTE_W-1:0], rx_data};
            if (byte_cnt == CNT_W'(FRAME_LAST)) begin
              byte_cnt <= '0;
              state    <= S_EXEC;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
`ifdef CMD_TIMEOUT_EN
          else if (to_hit_c) begin
            byte_cnt <= '0;
          end
`endif
        end

        S_EXEC: begin
          case (cmd_c)
            CMD_ADDR: begin
              ram_addr <= payload_c;
              reply    <= payload_c;
            end
            CMD_LOAD: begin
              ram_wdata <= payload_c;
              reply     <= payload_c;
            end
            CMD_WRITE: begin
              ram_wr_req <= !ram_busy;
              reply      <= REPLY_WRITE;
            end
            CMD_READ: begin
              reply <= rd_buf;
            end
            CMD_READ_REQ: begin
              ram_rd_req <= !ram_busy;
              reply      <= REPLY_READ_REQ;
            end
            CMD_COUNT: begin
              reply <= count;
              count <= count + WORD_W'(1);
            end
            CMD_CONST: begin
              reply <= CONST_WORD;
            end
            default: begin
              reply <= REPLY_BAD;
            end
          endcase
          if (!exec_stall_c) begin
            tx_cnt <= CNT_W'(REPLY_LEN);
            state  <= S_TX_LOAD;
          end
        end

        S_TX_LOAD: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= reply[WORD_W-1 -: BYTE_W];
            state    <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          // Transmitter has taken the byte once it reports busy
          if (!tx_ready) begin
            reply  <= {reply[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            tx_cnt <= tx_cnt - CNT_W'(1);
            if (tx_cnt == CNT_W'(1)) begin
              state <= S_RX;
            end else begin
              state <= S_TX_LOAD;
            end
          end
        end

        default: begin
          state <= S_RX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Bench for serial_cmd_ctrl: directed and random frames against a command-level model,
// with UART transmitter and RAM controller responders.
module tb_serial_cmd_ctrl;

  localparam int unsigned TB_TIMEOUT = 200;
  localparam logic [31:0] COUNT_INIT = 32'd260;
  localparam logic [31:0] CONST_WORD = 32'h01010101;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_strb;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wr_req;
  logic        ram_rd_req;
  logic        ram_busy;
  logic        ram_rd_valid = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        rx_overrun;

  serial_cmd_ctrl #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .COUNT_INIT    (COUNT_INIT),
    .CONST_WORD    (CONST_WORD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_strb     (rx_strb),
    .rx_data     (rx_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wr_req  (ram_wr_req),
    .ram_rd_req  (ram_rd_req),
    .ram_busy    (ram_busy),
    .ram_rd_valid(ram_rd_valid),
    .ram_rdata   (ram_rdata),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder state
  logic [7:0]  tx_q[$];
  int unsigned start_cyc[$];
  int          tx_rd = 0;
  int          tx_hold = 0;
  int          tx_viol = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rdv_cnt = 0;
  logic [31:0] wr_data_seen = '0;
  int          rd_pending = 0;
  int unsigned rd_req_cyc = 0;
  int          rd_delay = 20;
  logic [31:0] rd_ret = '0;
  int unsigned b5_cyc = 0;

  // UART transmitter and RAM controller behaviour, updated away from the active edge
  always @(negedge clk) begin
    ram_rd_valid = 1'b0;
    if (!rstn) begin
      tx_ready   = 1'b1;
      tx_hold    = 0;
      rd_pending = 0;
    end else begin
      if (tx_start) begin
        if (!tx_ready) tx_viol++;
        tx_q.push_back(tx_data);
        start_cyc.push_back(cyc);
        tx_ready = 1'b0;
        tx_hold  = $urandom_range(1, 4);
      end else if (tx_hold > 0) begin
        tx_hold--;
        if (tx_hold == 0) tx_ready = 1'b1;
      end
      if (ram_wr_req) begin
        wr_cnt++;
        wr_data_seen = ram_wdata;
      end
      if (rd_pending > 0) begin
        rd_pending--;
        if (rd_pending == 0) begin
          ram_rd_valid = 1'b1;
          ram_rdata    = rd_ret;
          rdv_cnt++;
        end
      end
      if (ram_rd_req) begin
        rd_cnt++;
        rd_req_cyc = cyc;
        rd_pending = rd_delay;
      end
    end
  end

  // Command-level reference model
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_count = COUNT_INIT;
  logic [31:0] m_rdbuf = '0;

  function automatic logic [31:0] model(input logic [7:0] c, input logic [31:0] p);
    logic [31:0] r;
    case (c)
      8'h01: begin m_addr = p; r = p; end
      8'h02: begin m_wdata = p; r = p; end
      8'h03: r = 32'd3;
      8'h04: r = m_rdbuf;
      8'h05: r = 32'd5;
      8'h06: begin r = m_count; m_count = m_count + 32'd1; end
      8'h07: r = CONST_WORD;
      default: r = 32'hFFFF_FFFF;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_addr  = '0;
    m_wdata = '0;
    m_count = COUNT_INIT;
    m_rdbuf = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tx_start"},   32'(tx_start),   32'd0);
    chk({tag, " tx_data"},    32'(tx_data),    32'd0);
    chk({tag, " ram_addr"},   ram_addr,        32'd0);
    chk({tag, " ram_wdata"},  ram_wdata,       32'd0);
    chk({tag, " ram_wr_req"}, 32'(ram_wr_req), 32'd0);
    chk({tag, " ram_rd_req"}, 32'(ram_rd_req), 32'd0);
    chk({tag, " rx_overrun"}, 32'(rx_overrun), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_strb = 1'b1;
    @(negedge clk);
    rx_strb = 1'b0;
    b5_cyc  = cyc;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input int gapmax);
    logic [39:0] f;
    f = {c, p};
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send_byte(f[39 - 8*i -: 8]);
    end
  endtask

  task automatic expect_reply(input string tag, input logic [31:0] rep);
    int n;
    n = 0;
    while ((tx_q.size() < tx_rd + 4) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " nbytes"}, 32'(tx_q.size() - tx_rd), 32'd4);
    if (tx_q.size() >= tx_rd + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s byte%0d", tag, i), 32'(tx_q[tx_rd]), (rep >> (8*(3-i))) & 32'hFF);
        tx_rd++;
      end
    end else begin
      tx_rd = tx_q.size();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] c, input logic [31:0] p,
                          input int busy_cyc);
    int wr0;
    int rd0;
    int n;
    logic [31:0] exp;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    exp = model(c, p);
    if (busy_cyc > 0) ram_busy = 1'b1;
    send_frame(c, p, 2);
    if (busy_cyc > 0) begin
      repeat (busy_cyc) @(negedge clk);
      chk({tag, " no req while busy"}, 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
      ram_busy = 1'b0;
    end
    expect_reply(tag, exp);
    chk({tag, " wr pulses"}, 32'(wr_cnt - wr0), (c == 8'h03) ? 32'd1 : 32'd0);
    chk({tag, " rd pulses"}, 32'(rd_cnt - rd0), (c == 8'h05) ? 32'd1 : 32'd0);
    if (c == 8'h03) chk({tag, " wdata at wr"}, wr_data_seen, m_wdata);
    if (c == 8'h05) begin
      n = 0;
      while ((rdv_cnt < rd_cnt) && (n < 200)) begin
        @(negedge clk);
        n++;
      end
      chk({tag, " rd_valid seen"}, 32'(rdv_cnt), 32'(rd_cnt));
      m_rdbuf = rd_ret;
    end
    chk({tag, " ram_addr"}, ram_addr, m_addr);
    chk({tag, " ram_wdata"}, ram_wdata, m_wdata);
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] p;
    logic [31:0] exp;
    int          base;
    int          n;
    int          r;
    int          busy;
    int unsigned target;

    rstn     = 1'b0;
    rx_strb  = 1'b0;
    rx_data  = '0;
    ram_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post-reset");

    // ADDR plus reply latency from the byte-5 edge
    base = tx_rd;
    do_frame("addr", 8'h01, 32'h0000_0104, 0);
    if (start_cyc.size() > base) chk("addr latency", start_cyc[base] - b5_cyc, 32'd2);

    do_frame("count0", 8'h06, 32'h0, 0);
    do_frame("count1", 8'h06, 32'h0, 0);

    do_frame("load", 8'h02, 32'hDEAD_BEEF, 0);
    do_frame("write busy", 8'h03, 32'h0, 10);

    rd_delay = 20;
    rd_ret   = 32'hCAFE_F00D;
    do_frame("read_req", 8'h05, 32'h0, 0);
    do_frame("read", 8'h04, 32'h0, 0);

    do_frame("const", 8'h07, 32'h1234_5678, 0);
    do_frame("bad cmd", 8'hA0, 32'h1111_2222, 0);

    // Read data returning in the same cycle the READ executes
    rd_delay = 80;
    rd_ret   = 32'h5A5A_0F0F;
    exp = model(8'h05, 32'h0);
    send_frame(8'h05, 32'h0, 0);
    expect_reply("rr coinc", exp);
    target = rd_req_cyc + 32'(rd_delay) - 1;
    send_byte(8'h04);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    chk("coinc timing room", 32'(cyc < target), 32'd1);
    n = 0;
    while ((cyc < target) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    exp = model(8'h04, 32'h0);
    send_byte(8'h00);
    expect_reply("read coinc old", exp);
    m_rdbuf = rd_ret;
    do_frame("read coinc new", 8'h04, 32'h0, 0);

    // Random command traffic
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      p = $urandom;
      case (r)
        0, 1: c = 8'h01;
        2:    c = 8'h02;
        3:    c = 8'h06;
        4:    c = 8'h07;
        5:    c = 8'h04;
        6:    c = 8'h03;
        7:    c = 8'h05;
        8:    c = 8'($urandom_range(8, 255));
        default: c = 8'h00;
      endcase
      busy = ((c == 8'h03) || (c == 8'h05)) ? $urandom_range(0, 6) : 0;
      if (c == 8'h05) begin
        rd_delay = $urandom_range(2, 25);
        rd_ret   = $urandom;
      end
      do_frame($sformatf("rand%0d", it), c, p, busy);
    end

    // Byte arriving while a reply is in flight
    chk("overrun before", 32'(rx_overrun), 32'd0);
    exp = model(8'h06, 32'h0);
    send_frame(8'h06, 32'h0, 0);
    n = 0;
    while ((tx_q.size() < tx_rd + 1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h55);
    expect_reply("overrun frame", exp);
    chk("overrun set", 32'(rx_overrun), 32'd1);
    do_frame("after overrun", 8'h06, 32'h0, 0);

`ifdef CMD_TIMEOUT_EN
    for (int i = 0; i < 3; i++) send_byte(8'h33);
    repeat (TB_TIMEOUT + 20) @(negedge clk);
    do_frame("timeout const", 8'h07, 32'h0, 0);
`endif

    // Reset in the middle of a reply
    exp = model(8'h06, 32'h0);
    send_frame(8'h06, 32'h0, 0);
    n = 0;
    while ((tx_q.size() < tx_rd + 2) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid-reply reset");
    base = tx_q.size();
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("no tx after reset", 32'(tx_q.size()), 32'(base));
    chk_reset_outputs("after mid reset");
    tx_rd = tx_q.size();
    model_reset();

    do_frame("count after reset", 8'h06, 32'h0, 0);
    do_frame("read after reset", 8'h04, 32'h0, 0);

    // Byte arriving in the EXEC cycle right after byte 5
    exp = model(8'h07, 32'h0);
    send_frame(8'h07, 32'h0, 0);
    send_byte(8'hEE);
    expect_reply("exec drop", exp);
    chk("exec drop overrun", 32'(rx_overrun), 32'd1);
    do_frame("after exec drop", 8'h01, 32'h0BAD_F00D, 0);

    chk("tx_start handshake", 32'(tx_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_cmd_ctrl.md
# serial_cmd_ctrl

Byte-serial command controller between the UART pair and the HyperRAM controller. Assembles 5-byte command frames (1 command byte plus 32-bit big-endian payload) from the UART receiver, decodes them, and issues address, write-data, write and read requests to the RAM controller. Streams a 4-byte big-endian reply through the UART transmitter using its start/ready handshake. This replaces the ad-hoc frame handling used in bench-level command tests.

## Interface
- `TIMEOUT_CYCLES`, 100000: idle cycles after which a partial frame is discarded (only with `CMD_TIMEOUT_EN`).
- `COUNT_INIT`, 32'd260: reset value of the COUNT register.
- `CONST_WORD`, 32'h01010101: reply word for CONST.

- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `rx_strb`  in  1  one-cycle pulse; `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `tx_start`  out  1  one-cycle start pulse to the UART transmitter.
- `tx_data`  out  8  byte to transmit; held stable while `tx_start` is high.
- `tx_ready`  in  1  transmitter idle; falls within 2 cycles of `tx_start`.
- `ram_addr`  out  32  RAM address register.
- `ram_wdata`  out  32  RAM write-data register.
- `ram_wr_req`  out  1  one-cycle write request.
- `ram_rd_req`  out  1  one-cycle read request.
- `ram_busy`  in  1  RAM controller cannot accept a request.
- `ram_rd_valid`  in  1  one-cycle pulse; `ram_rdata` is valid.
- `ram_rdata`  in  32  read data.
- `rx_overrun`  out  1  sticky; set when a byte was dropped. Cleared only by reset.

## Operation
- States: RX, EXEC, TX_LOAD, TX_WAIT.
- **RX**
  - Each `rx_strb` shifts `rx_data` into a 40-bit frame register, MSB first, and increments a 3-bit byte count.
  - When the 5th byte is accepted, the byte count is cleared and the state moves to EXEC.
- **EXEC** (command = frame[39:32], payload = frame[31:0])
  - 0x01 ADDR: `ram_addr` <= payload; reply = payload.
  - 0x02 LOAD: `ram_wdata` <= payload; reply = payload.
  - 0x03 WRITE: stalls while `ram_busy`=1, then pulses `ram_wr_req`; reply = 32'h3.
  - 0x04 READ: reply = rd_buf (last captured read data).
  - 0x05 READ_REQ: stalls while `ram_busy`=1, then pulses `ram_rd_req`; reply = 32'h5.
  - 0x06 COUNT: reply = count; count <= count+1, modulo 2^32 (0xFFFFFFFF wraps to 0).
  - 0x07 CONST: reply = `CONST_WORD`.
  - Any other command: reply = 32'hFFFFFFFF. No side effects.
  - After EXEC: the reply word is latched, tx byte count = 4, state moves to TX_LOAD.
- **rd_buf capture:** rd_buf <= `ram_rdata` on every `ram_rd_valid`, in any state. It holds its value until the next pulse.
- **TX_LOAD:** waits for `tx_ready`=1, then drives `tx_start`=1 for one cycle with `tx_data` = reply[31:24]. Moves to TX_WAIT.
- **TX_WAIT:**
  - Waits for `tx_ready`=0, then shifts the reply left by 8 and decrements the tx byte count.
  - If the count is now 0, go to RX; otherwise go to TX_LOAD.
- **Dropped bytes:** an `rx_strb` in any state other than RX drops the byte and sets `rx_overrun`.

## Timing
- **Reset values:**
  - Outputs: `tx_start`, `tx_data`, `ram_addr`, `ram_wdata`, `ram_wr_req`, `ram_rd_req`, `rx_overrun` all 0.
  - Internal: state RX, byte count 0, rd_buf 0, count = `COUNT_INIT`.
- **Outputs:** all outputs are registered.
- **EXEC entry:** EXEC is active in the cycle after the edge that accepts byte 5.
- **RAM requests:** `ram_wr_req`/`ram_rd_req` are high for exactly the one cycle after the EXEC edge that sees `ram_busy`=0.
- **Latency, idle RAM and ready transmitter:** `tx_start` first goes high 2 cycles after the byte-5 edge.
- **`tx_start` rule:** never reasserted until `tx_ready` has been observed low after the previous pulse. Exactly 4 pulses per frame.
- **`rx_strb` in the same cycle as a state change out of RX:** the byte is dropped.
- **`ram_rd_valid` coincident with a READ in EXEC:** the reply is the old rd_buf value.
- **Reset mid-frame or mid-reply:** the partial frame and the remaining reply bytes are discarded immediately.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - In RX with byte count in 1–4, a counter increments on each cycle with no `rx_strb` and resets to 0 on `rx_strb`.
  - When it reaches `TIMEOUT_CYCLES`, the byte count is cleared and the partial frame is discarded.
- Undefined: no counter is built; a partial frame waits indefinitely.

## Test plan
- **ADDR:** frame 01 00 00 01 04 -> `ram_addr`=0x00000104; tx bytes 00 00 01 04.
- **COUNT:** two COUNT frames (06 00 00 00 00) -> replies 00 00 01 04, then 00 00 01 05.
- **LOAD + WRITE:**
  - Stimulus: LOAD 0xDEADBEEF, then WRITE with `ram_busy` held high for 10 cycles.
  - Required: a single `ram_wr_req` pulse, only after busy drops, with `ram_wdata`=0xDEADBEEF; reply 00 00 00 03.
- **READ_REQ + READ:** READ_REQ; RAM model returns `ram_rd_valid` with 0xCAFEF00D after 20 cycles; then READ -> reply CA FE F0 0D.
- **Overrun:** extra byte injected during TX_WAIT -> `rx_overrun`=1; the following COUNT frame still decodes correctly.
- **Timeout and reset:**
  - With `CMD_TIMEOUT_EN`: 3 bytes, a gap > `TIMEOUT_CYCLES`, then a full CONST frame -> reply 01 01 01 01.
  - `rstn` pulsed after the 2nd reply byte -> no further `tx_start`; all outputs return to reset values.
